// File: rtl/pixel_src_mux_n.sv
// Registered N-to-1 pixel source selector with frame-synchronous select update and auto-rotate.
// Optional blanking input is enabled by defining PIXMUX_BLANK_EN.
module pixel_src_mux_n #(
  parameter int               NUM_IN        = 5,
  parameter int               WIDTH         = 4,
  parameter int               ROTATE_FRAMES = 60,
  parameter logic [WIDTH-1:0] DEFAULT_VAL   = '0,
  localparam int              SEL_W         = ($clog2(NUM_IN) > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    sel_wr,
  input  logic                    frame_start,
  input  logic                    auto_en,
`ifdef PIXMUX_BLANK_EN
  input  logic                    blank,
`endif
  output logic [WIDTH-1:0]        pix_out,
  output logic [SEL_W-1:0]        sel_active,
  output logic                    sel_pending,
  output logic                    sel_err
);

  localparam int               CNT_W    = ($clog2(ROTATE_FRAMES) > 1) ? $clog2(ROTATE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROTATE_FRAMES - 1);
  localparam logic [31:0]      NUM_IN_U = NUM_IN;

  logic [SEL_W-1:0] sel_active_q, sel_active_d;
  logic [SEL_W-1:0] shadow_q, shadow_d;
  logic             sel_pending_q, sel_pending_d;
  logic             sel_err_q, sel_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [WIDTH-1:0] pix_out_q, pix_out_d;
  logic [WIDTH-1:0] mux_val;

  // Select control: a write coinciding with frame_start takes effect directly,
  // a pending shadow write blocks rotation for that frame.
  always_comb begin
    sel_active_d  = sel_active_q;
    shadow_d      = shadow_q;
    sel_pending_d = sel_pending_q;
    frame_cnt_d   = frame_cnt_q;

    if (sel_wr) begin
      shadow_d      = sel_in;
      sel_pending_d = 1'b1;
    end

    if (frame_start) begin
      if (sel_wr) begin
        sel_active_d  = sel_in;
        sel_pending_d = 1'b0;
        frame_cnt_d   = '0;
      end else if (sel_pending_q) begin
        sel_active_d  = shadow_q;
        sel_pending_d = 1'b0;
        frame_cnt_d   = '0;
      end else if (auto_en) begin
        if (frame_cnt_q == CNT_LAST) begin
          frame_cnt_d = '0;
          if (32'(sel_active_q) >= NUM_IN_U - 32'd1) begin
            sel_active_d = '0;
          end else begin
            sel_active_d = sel_active_q + SEL_W'(1);
          end
        end else begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
      end
    end

    if (!auto_en) begin
      frame_cnt_d = '0;
    end

    sel_err_d = (32'(sel_active_d) >= NUM_IN_U);
  end

  // Mux uses the select currently in force, so a new select appears one edge later.
  always_comb begin
    mux_val = DEFAULT_VAL;
    for (int i = 0; i < NUM_IN; i++) begin
      if (32'(sel_active_q) == 32'(i)) begin
        mux_val = in_bus[i*WIDTH +: WIDTH];
      end
    end
`ifdef PIXMUX_BLANK_EN
    pix_out_d = blank ? '0 : mux_val;
`else
    pix_out_d = mux_val;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_active_q  <= '0;
      shadow_q      <= '0;
      sel_pending_q <= 1'b0;
      sel_err_q     <= 1'b0;
      frame_cnt_q   <= '0;
      pix_out_q     <= '0;
    end else begin
      sel_active_q  <= sel_active_d;
      shadow_q      <= shadow_d;
      sel_pending_q <= sel_pending_d;
      sel_err_q     <= sel_err_d;
      frame_cnt_q   <= frame_cnt_d;
      pix_out_q     <= pix_out_d;
    end
  end

  assign pix_out     = pix_out_q;
  assign sel_active  = sel_active_q;
  assign sel_pending = sel_pending_q;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_pixel_src_mux_n.sv
// Directed self-checking bench for pixel_src_mux_n; two instances share stimulus
// (ROTATE_FRAMES=3 and ROTATE_FRAMES=2). Blank checks run when PIXMUX_BLANK_EN is defined.
module tb_pixel_src_mux_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] in_bus = 20'hCA321;
  logic [2:0]  sel_in = 3'd0;
  logic        sel_wr = 1'b0;
  logic        frame_start = 1'b0;
  logic        auto_en = 1'b0;
  logic        blank = 1'b0;

  logic [3:0]  pix_out, pix_out2;
  logic [2:0]  sel_active, sel_active2;
  logic        sel_pending, sel_pending2;
  logic        sel_err, sel_err2;

  int compared = 0;
  int mismatched = 0;
  int exp5 [6] = '{4, 4, 0, 0, 0, 1};
  int exp5b [3] = '{2, 2, 3};

  always #5 clk = ~clk;

  pixel_src_mux_n #(.NUM_IN(5), .WIDTH(4), .ROTATE_FRAMES(3), .DEFAULT_VAL(4'h5)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel_in(sel_in), .sel_wr(sel_wr),
    .frame_start(frame_start), .auto_en(auto_en),
`ifdef PIXMUX_BLANK_EN
    .blank(blank),
`endif
    .pix_out(pix_out), .sel_active(sel_active), .sel_pending(sel_pending), .sel_err(sel_err)
  );

  pixel_src_mux_n #(.NUM_IN(5), .WIDTH(4), .ROTATE_FRAMES(2), .DEFAULT_VAL(4'h5)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel_in(sel_in), .sel_wr(sel_wr),
    .frame_start(frame_start), .auto_en(auto_en),
`ifdef PIXMUX_BLANK_EN
    .blank(blank),
`endif
    .pix_out(pix_out2), .sel_active(sel_active2), .sel_pending(sel_pending2), .sel_err(sel_err2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle with the given inputs; strobes are dropped just after the edge.
  task automatic applyStimulus(input logic [2:0] s, input logic wr, input logic fs);
    sel_in      = s;
    sel_wr      = wr;
    frame_start = fs;
    @(posedge clk);
    #1;
    sel_wr      = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    #2;
    checkOutput("reset_pix", 32'(pix_out), 32'h0);
    checkOutput("reset_sel", 32'(sel_active), 32'h0);
    checkOutput("reset_pend", 32'(sel_pending), 32'h0);
    checkOutput("reset_err", 32'(sel_err), 32'h0);
    #10;
    rst_n = 1'b1;
    applyStimulus(3'd0, 1'b0, 1'b0);
    checkOutput("src0_pix", 32'(pix_out), 32'h1);

    // Basic select: shadow write, then frame_start ten cycles later
    applyStimulus(3'd3, 1'b1, 1'b0);
    checkOutput("wr_pend", 32'(sel_pending), 32'h1);
    checkOutput("wr_sel_hold", 32'(sel_active), 32'h0);
    for (int i = 0; i < 9; i++) applyStimulus(3'd0, 1'b0, 1'b0);
    checkOutput("wait_pend", 32'(sel_pending), 32'h1);
    checkOutput("wait_sel", 32'(sel_active), 32'h0);
    checkOutput("wait_pix", 32'(pix_out), 32'h1);
    applyStimulus(3'd0, 1'b0, 1'b1);
    checkOutput("fs_sel", 32'(sel_active), 32'h3);
    checkOutput("fs_pend", 32'(sel_pending), 32'h0);
    checkOutput("fs_pix_old", 32'(pix_out), 32'h1);
    applyStimulus(3'd0, 1'b0, 1'b0);
    checkOutput("fs_pix_new", 32'(pix_out), 32'hA);

    // Simultaneous write and frame_start beats an older shadow value
    applyStimulus(3'd1, 1'b1, 1'b0);
    checkOutput("sim_pend", 32'(sel_pending), 32'h1);
    applyStimulus(3'd2, 1'b1, 1'b1);
    checkOutput("sim_sel", 32'(sel_active), 32'h2);
    checkOutput("sim_pend0", 32'(sel_pending), 32'h0);
    applyStimulus(3'd0, 1'b0, 1'b0);
    checkOutput("sim_pix", 32'(pix_out), 32'h3);

    // Asynchronous reset mid-cycle with a pending write
    applyStimulus(3'd4, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_pix", 32'(pix_out), 32'h0);
    checkOutput("arst_sel", 32'(sel_active), 32'h0);
    checkOutput("arst_pend", 32'(sel_pending), 32'h0);
    rst_n = 1'b1;
    applyStimulus(3'd0, 1'b0, 1'b0);
    checkOutput("arst_pix_src0", 32'(pix_out), 32'h1);

    // Out-of-range select, then auto-rotate wraps back to source 0
    applyStimulus(3'd6, 1'b1, 1'b1);
    checkOutput("oor_sel", 32'(sel_active), 32'h6);
    checkOutput("oor_err", 32'(sel_err), 32'h1);
    applyStimulus(3'd0, 1'b0, 1'b0);
    checkOutput("oor_pix", 32'(pix_out), 32'h5);
    auto_en = 1'b1;
    applyStimulus(3'd0, 1'b0, 1'b1);
    applyStimulus(3'd0, 1'b0, 1'b0);
    checkOutput("oor_rf2_hold", 32'(sel_active2), 32'h6);
    applyStimulus(3'd0, 1'b0, 1'b1);
    checkOutput("oor_rf2_sel", 32'(sel_active2), 32'h0);
    checkOutput("oor_rf2_err", 32'(sel_err2), 32'h0);
    checkOutput("oor_rf3_sel", 32'(sel_active), 32'h6);
    checkOutput("oor_rf3_err", 32'(sel_err), 32'h1);
    applyStimulus(3'd0, 1'b0, 1'b0);
    checkOutput("oor_rf2_pix", 32'(pix_out2), 32'h1);

    // Auto-rotate wrap from source 4 with ROTATE_FRAMES=3
    applyStimulus(3'd4, 1'b1, 1'b1);
    checkOutput("rot_start", 32'(sel_active), 32'h4);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'd0, 1'b0, 1'b1);
      checkOutput($sformatf("rot_%0d", i), 32'(sel_active), 32'(exp5[i]));
      applyStimulus(3'd0, 1'b0, 1'b0);
    end
    applyStimulus(3'd2, 1'b1, 1'b0);
    checkOutput("rot_wr_pend", 32'(sel_pending), 32'h1);
    checkOutput("rot_wr_hold", 32'(sel_active), 32'h1);
    applyStimulus(3'd0, 1'b0, 1'b1);
    checkOutput("rot_ovr", 32'(sel_active), 32'h2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'd0, 1'b0, 0);
      applyStimulus(3'd0, 1'b0, 1'b1);
      checkOutput($sformatf("rot_restart_%0d", i), 32'(sel_active), 32'(exp5b[i]));
    end
    auto_en = 1'b0;
    applyStimulus(3'd0, 1'b0, 1'b0);
    checkOutput("rot_pix", 32'(pix_out), 32'hA);

`ifdef PIXMUX_BLANK_EN
    blank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'd0, 1'b0, 1'b0);
      checkOutput($sformatf("blank_%0d", i), 32'(pix_out), 32'h0);
    end
    blank = 1'b0;
    applyStimulus(3'd0, 1'b0, 1'b0);
    checkOutput("blank_end_pix", 32'(pix_out), 32'hA);
    checkOutput("blank_sel", 32'(sel_active), 32'h3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
